lpc_dec_arbiter: RTL and testbench
==================================

LPC_DEC_ARBITER -- requirements
Module: lpc_dec_arbiter

Interface
REQ-001 The block SHALL have parameter WD_CYCLES, default 255, which sets the watchdog limit in idle cycles (legal range 1..65535).
REQ-002 ACLK  in  1  clock; all logic SHALL be rising-edge.
REQ-003 ARESET_N  in  1  reset, asynchronous, active-low.
REQ-004 S_TDATA  in  320  4 requester codewords, port p at bits [80p+79:80p].
REQ-005 S_TVALID / S_TUSER / S_TLAST  in  4 each  per-port stream sideband, bit p = port p.
REQ-006 S_TREADY  out  4  per-port ready.
REQ-007 EN_MASK  in  4  per-port correction enable.
REQ-008 D_TDATA 80, D_TVALID 1, D_EN 1, D_TUSER 1, D_TLAST 1  out  codeword stream to the shared decoder.
REQ-009 D_TREADY  in  1  decoder input ready.
REQ-010 D_OUT_DECODED 16, D_OUT_VALID 1, D_OUT_LAST 1, D_OUT_USER 1  in  decoder output stream.
REQ-011 D_OUT_READY  out  1  decoder output ready.
REQ-012 M_TDATA 16, M_TVALID 1, M_TLAST 1, M_TUSER 1  out  merged decoded stream.
REQ-013 M_TID  out  2  source port of the current M beat.
REQ-014 M_TREADY  in  1  merged stream ready.
REQ-015 WD_ERR  out  4  sticky per-port watchdog flags.
REQ-016 WD_CLR  in  4  per-port clear for WD_ERR.

Function
REQ-017 The FSM SHALL have states IDLE (arbitrate) and LOCKED (forward the granted port).
REQ-018 In IDLE, when any S_TVALID is set, the block SHALL grant the first valid port searching from last_grant+1 modulo 4, and SHALL enter LOCKED on the next edge (1 cycle arbitration latency).
REQ-019 In IDLE, all S_TREADY bits and D_TVALID SHALL be 0.
REQ-020 In LOCKED, D_TDATA/D_TVALID/D_TUSER/D_TLAST SHALL combinationally mirror the granted port, D_EN SHALL equal EN_MASK[grant], and S_TREADY[grant] SHALL equal D_TREADY; all other S_TREADY bits SHALL be 0.
REQ-021 A handshake (D_TVALID & D_TREADY) SHALL load tid_reg with grant and clear the watchdog counter.
REQ-022 A handshake with S_TLAST[grant]=1 SHALL return the FSM to IDLE and set last_grant to grant; codewords of different frames SHALL never interleave.
REQ-023 In LOCKED, each cycle with S_TVALID[grant]=0 SHALL increment a 16-bit watchdog counter; when the counter reaches WD_CYCLES, the block SHALL set WD_ERR[grant], set last_grant to grant, and return to IDLE.
REQ-024 When WD_CLR[p] and a watchdog set for port p occur in the same cycle, the set SHALL win.
REQ-025 M_TDATA/M_TVALID/M_TLAST/M_TUSER SHALL combinationally mirror the D_OUT inputs, D_OUT_READY SHALL equal M_TREADY, and M_TID SHALL equal tid_reg.
REQ-026 tid_reg SHALL remain valid for all 4 output beats because the decoder accepts no new codeword until its output drains; the block SHALL NOT buffer output data.
REQ-027 A new arbitration SHALL be allowed while the decoder still drains output; M_TID SHALL be unaffected until the next input handshake.

Reset
REQ-028 On ARESET_N low, the block SHALL set: state IDLE, last_grant 3 (port 0 first), grant 0, tid_reg 0, watchdog counter 0, WD_ERR 0, S_TREADY 0, D_TVALID 0, M_TID 0.
REQ-029 A reset mid-frame SHALL abandon the frame with no partial codeword issued after release; the decoder SHALL share the same reset.

Configuration
REQ-030 With LPC_ARB_PRIO_EN defined, IDLE arbitration SHALL grant port 0 whenever S_TVALID[0]=1 and SHALL round-robin among ports 1-3 otherwise.
REQ-031 Without LPC_ARB_PRIO_EN, arbitration SHALL be pure 4-way round-robin per REQ-018.

Verification
REQ-032 The bench SHALL drive all 4 ports with continuous single-codeword frames (TLAST=1) and check grant order 0,1,2,3,0 with M_TID matching each 4-beat output group.
REQ-033 The bench SHALL send a 3-codeword frame on port 2 while port 1 is valid and check that port 1 is granted only after port 2's TLAST handshake.
REQ-034 The bench SHALL set EN_MASK=4'b0010, send a single-bit-flip codeword on ports 0 and 1, and check that port 1 output is corrected and port 0 output is uncorrected.
REQ-035 The bench SHALL use WD_CYCLES=4, drop port 3 TVALID mid-frame, and check that WD_ERR=4'b1000 after 4 idle cycles, then port 0 is granted next, then WD_CLR[3] clears the flag.
REQ-036 The bench SHALL assert ARESET_N low during LOCKED with M_TREADY=0 and check all outputs at reset values and the first post-reset grant is port 0.
REQ-037 With LPC_ARB_PRIO_EN defined, the bench SHALL hold ports 0 and 2 valid and check that port 0 wins every arbitration.

Source files
------------

// File: rtl/lpc_dec_arbiter.sv
// 4-port round-robin arbiter feeding one shared codeword decoder, with per-port idle watchdog.
// Define LPC_ARB_PRIO_EN to give port 0 strict priority over round-robin ports 1-3.
module lpc_dec_arbiter #(
    parameter int unsigned WD_CYCLES = 255
) (
    input  logic         ACLK,
    input  logic         ARESET_N,
    input  logic [319:0] S_TDATA,
    input  logic [3:0]   S_TVALID,
    input  logic [3:0]   S_TUSER,
    input  logic [3:0]   S_TLAST,
    output logic [3:0]   S_TREADY,
    input  logic [3:0]   EN_MASK,
    output logic [79:0]  D_TDATA,
    output logic         D_TVALID,
    output logic         D_EN,
    output logic         D_TUSER,
    output logic         D_TLAST,
    input  logic         D_TREADY,
    input  logic [15:0]  D_OUT_DECODED,
    input  logic         D_OUT_VALID,
    input  logic         D_OUT_LAST,
    input  logic         D_OUT_USER,
    output logic         D_OUT_READY,
    output logic [15:0]  M_TDATA,
    output logic         M_TVALID,
    output logic         M_TLAST,
    output logic         M_TUSER,
    output logic [1:0]   M_TID,
    input  logic         M_TREADY,
    output logic [3:0]   WD_ERR,
    input  logic [3:0]   WD_CLR
);

    localparam int unsigned PORTS = 4;
    localparam int unsigned CW_W  = 80;
    localparam int unsigned WD_W  = 16;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WD_CYCLES);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state_q;
    logic [1:0]           grant_q;
    logic [1:0]           last_grant_q;
    logic [1:0]           tid_q;
    logic [WD_W-1:0]      wd_cnt_q;
    logic [PORTS-1:0]     wd_err_q;

    logic [PORTS-1:0][CW_W-1:0] s_data_c;
    logic [1:0]           pick_c;
    logic                 locked_c;
    logic                 g_valid_c;
    logic                 hs_c;
    logic [WD_W-1:0]      wd_inc_c;
    logic                 wd_fire_c;
    logic [PORTS-1:0]     wd_set_c;

    assign s_data_c = S_TDATA;

    // Next grant: first requester after the last served port
    always_comb begin : arb_pick
        logic [PORTS-1:0] cand;
        logic [1:0]       idx;
        logic             found;
        cand   = S_TVALID;
        idx    = 2'd0;
        found  = 1'b0;
        pick_c = 2'd0;
`ifdef LPC_ARB_PRIO_EN
        cand = S_TVALID & 4'b1110;
`endif
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant_q + 2'(i);
            if (!found && cand[idx]) begin
                pick_c = idx;
                found  = 1'b1;
            end
        end
`ifdef LPC_ARB_PRIO_EN
        if (S_TVALID[0]) pick_c = 2'd0;
`endif
    end

    assign locked_c  = (state_q == LOCKED);
    assign g_valid_c = S_TVALID[grant_q];
    assign hs_c      = D_TVALID & D_TREADY;
    assign wd_inc_c  = wd_cnt_q + WD_W'(1);
    assign wd_fire_c = locked_c & ~g_valid_c & (wd_inc_c == WD_LIMIT);
    assign wd_set_c  = wd_fire_c ? (4'b0001 << grant_q) : 4'b0000;

    // Codeword path mirrors the granted port while locked
    assign D_TDATA  = s_data_c[grant_q];
    assign D_TVALID = locked_c & g_valid_c;
    assign D_EN     = EN_MASK[grant_q];
    assign D_TUSER  = S_TUSER[grant_q];
    assign D_TLAST  = S_TLAST[grant_q];

    always_comb begin
        S_TREADY = '0;
        if (locked_c) S_TREADY[grant_q] = D_TREADY;
    end

    // Decoded stream is passed through unbuffered; tid_q tags it
    assign M_TDATA     = D_OUT_DECODED;
    assign M_TVALID    = D_OUT_VALID;
    assign M_TLAST     = D_OUT_LAST;
    assign M_TUSER     = D_OUT_USER;
    assign D_OUT_READY = M_TREADY;
    assign M_TID       = tid_q;
    assign WD_ERR      = wd_err_q;

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            tid_q        <= 2'd0;
            wd_cnt_q     <= '0;
            wd_err_q     <= '0;
        end else begin
            // A watchdog set outranks a simultaneous clear
            wd_err_q <= (wd_err_q & ~WD_CLR) | wd_set_c;
            case (state_q)
                IDLE: begin
                    if (|S_TVALID) begin
                        grant_q  <= pick_c;
                        wd_cnt_q <= '0;
                        state_q  <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (hs_c) begin
                        tid_q    <= grant_q;
                        wd_cnt_q <= '0;
                        if (D_TLAST) begin
                            state_q      <= IDLE;
                            last_grant_q <= grant_q;
                        end
                    end else if (!g_valid_c) begin
                        if (wd_fire_c) begin
                            wd_cnt_q     <= '0;
                            state_q      <= IDLE;
                            last_grant_q <= grant_q;
                        end else begin
                            wd_cnt_q <= wd_inc_c;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_dec_arbiter.sv
// Bench for lpc_dec_arbiter: stub 5x-repetition decoder plus a frame-level arbitration model.
// Build with LPC_ARB_PRIO_EN defined to exercise the port-0 priority variant.
`timescale 1ns/1ps
module tb_lpc_dec_arbiter;

    typedef struct packed {
        logic [15:0] w;
        logic [15:0] flip;
        logic        user;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [1:0]  tid;
        logic [15:0] data;
        logic        last;
        logic        user;
    } obeat_t;

    logic         ACLK = 1'b0;
    logic         ARESET_N = 1'b0;
    logic [319:0] S_TDATA = '0;
    logic [3:0]   S_TVALID = '0, S_TUSER = '0, S_TLAST = '0, EN_MASK = '1, WD_CLR = '0;
    logic [3:0]   S_TREADY, WD_ERR;
    logic [79:0]  D_TDATA;
    logic         D_TVALID, D_EN, D_TUSER, D_TLAST, D_TREADY;
    logic [15:0]  D_OUT_DECODED;
    logic         D_OUT_VALID, D_OUT_LAST, D_OUT_USER, D_OUT_READY;
    logic [15:0]  M_TDATA;
    logic         M_TVALID, M_TLAST, M_TUSER;
    logic         M_TREADY = 1'b1;
    logic [1:0]   M_TID;

    int vectors = 0;
    int miscompares = 0;
    int model_last = 3;
    beat_t  srcq[4][$];
    obeat_t expq[$];
    obeat_t got[$];

    always #5 ACLK = ~ACLK;

    lpc_dec_arbiter #(.WD_CYCLES(4)) dut (
        .ACLK(ACLK), .ARESET_N(ARESET_N),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TUSER(S_TUSER), .S_TLAST(S_TLAST),
        .S_TREADY(S_TREADY), .EN_MASK(EN_MASK),
        .D_TDATA(D_TDATA), .D_TVALID(D_TVALID), .D_EN(D_EN), .D_TUSER(D_TUSER),
        .D_TLAST(D_TLAST), .D_TREADY(D_TREADY),
        .D_OUT_DECODED(D_OUT_DECODED), .D_OUT_VALID(D_OUT_VALID), .D_OUT_LAST(D_OUT_LAST),
        .D_OUT_USER(D_OUT_USER), .D_OUT_READY(D_OUT_READY),
        .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TLAST(M_TLAST), .M_TUSER(M_TUSER),
        .M_TID(M_TID), .M_TREADY(M_TREADY), .WD_ERR(WD_ERR), .WD_CLR(WD_CLR)
    );

    // Decoder stub: codeword is a 16-bit word repeated 5 times; emits word+k for beats k=0..3
    logic        dec_busy, dec_en, dec_user;
    logic [1:0]  dec_beat;
    logic [79:0] dec_cw;
    logic [15:0] dec_word;

    function automatic logic [15:0] maj5(input logic [79:0] cw);
        logic [15:0] r;
        int n;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            n = 0;
            for (int s = 0; s < 5; s++) n += int'(cw[s*16+b]);
            r[b] = (n >= 3);
        end
        return r;
    endfunction

    assign dec_word      = dec_en ? maj5(dec_cw) : dec_cw[15:0];
    assign D_TREADY      = !dec_busy;
    assign D_OUT_VALID   = dec_busy;
    assign D_OUT_DECODED = dec_word + 16'(dec_beat);
    assign D_OUT_LAST    = (dec_beat == 2'd3);
    assign D_OUT_USER    = dec_user;

    always @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            dec_busy <= 1'b0; dec_beat <= 2'd0; dec_cw <= '0; dec_en <= 1'b0; dec_user <= 1'b0;
        end else if (!dec_busy) begin
            if (D_TVALID) begin
                dec_busy <= 1'b1; dec_beat <= 2'd0;
                dec_cw <= D_TDATA; dec_en <= D_EN; dec_user <= D_TUSER;
            end
        end else if (D_OUT_READY) begin
            if (dec_beat == 2'd3) dec_busy <= 1'b0;
            dec_beat <= dec_beat + 2'd1;
        end
    end

    always @(negedge ACLK) begin
        obeat_t o;
        if (ARESET_N && M_TVALID && M_TREADY) begin
            o.tid = M_TID; o.data = M_TDATA; o.last = M_TLAST; o.user = M_TUSER;
            got.push_back(o);
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    function automatic int model_pick(input int last, input logic [3:0] pend);
`ifdef LPC_ARB_PRIO_EN
        if (pend[0]) return 0;
`endif
        for (int i = 1; i <= 4; i++) if (pend[(last + i) % 4]) return (last + i) % 4;
        return 0;
    endfunction

    task automatic add_frame(input int p, input int len, input bit flip_en);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.w    = 16'($urandom);
            b.flip = flip_en ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            b.user = 1'($urandom);
            b.last = (i == len - 1);
            srcq[p].push_back(b);
        end
    endtask

    // Frame-level model: whole frames served in arbitration order, 4 output beats per codeword
    task automatic build_expected();
        int idx[4];
        logic [3:0] pend;
        int p;
        bit done;
        beat_t b;
        obeat_t o;
        foreach (idx[i]) idx[i] = 0;
        done = 1'b0;
        while (!done) begin
            for (int q = 0; q < 4; q++) pend[q] = (idx[q] < srcq[q].size());
            if (pend == 4'd0) begin
                done = 1'b1;
            end else begin
                p = model_pick(model_last, pend);
                do begin
                    b = srcq[p][idx[p]];
                    idx[p]++;
                    for (int k = 0; k < 4; k++) begin
                        o.tid  = 2'(p);
                        o.data = (EN_MASK[p] ? b.w : (b.w ^ b.flip)) + 16'(k);
                        o.last = (k == 3);
                        o.user = b.user;
                        expq.push_back(o);
                    end
                end while (!b.last && idx[p] < srcq[p].size());
                model_last = p;
            end
        end
    endtask

    task automatic drive_src(input int ptr[4]);
        beat_t b;
        for (int p = 0; p < 4; p++) begin
            if (ptr[p] < srcq[p].size()) begin
                b = srcq[p][ptr[p]];
                S_TVALID[p] = 1'b1;
                S_TDATA[p*80 +: 80] = {5{b.w}} ^ {64'd0, b.flip};
                S_TUSER[p] = b.user;
                S_TLAST[p] = b.last;
            end else begin
                S_TVALID[p] = 1'b0; S_TUSER[p] = 1'b0; S_TLAST[p] = 1'b0;
            end
        end
    endtask

    task automatic compare_groups(input string name);
        vectors++;
        if (got.size() != expq.size()) begin
            miscompares++;
            $display("FAIL %s beat_count: got %0d, required %0d", name, got.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== expq[i]) begin
                miscompares++;
                $display("FAIL %s beat %0d: got tid=%0d data=%h last=%b user=%b, required tid=%0d data=%h last=%b user=%b",
                         name, i, got[i].tid, got[i].data, got[i].last, got[i].user,
                         expq[i].tid, expq[i].data, expq[i].last, expq[i].user);
            end
        end
    endtask

    task automatic run_traffic(input string name, input bit bp);
        int ptr[4];
        logic [3:0] hs;
        int cyc;
        bit pend;
        expq.delete(); got.delete();
        build_expected();
        foreach (ptr[p]) ptr[p] = 0;
        drive_src(ptr);
        M_TREADY = 1'b1;
        cyc = 0; pend = 1'b1;
        while ((pend || got.size() < expq.size()) && cyc < 4000) begin
            @(negedge ACLK);
            hs = S_TVALID & S_TREADY;
            @(posedge ACLK); #1;
            for (int p = 0; p < 4; p++) if (hs[p]) ptr[p]++;
            drive_src(ptr);
            M_TREADY = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            pend = 1'b0;
            for (int p = 0; p < 4; p++) if (ptr[p] < srcq[p].size()) pend = 1'b1;
            cyc++;
        end
        vectors++;
        if (cyc >= 4000) begin
            miscompares++;
            $display("FAIL %s timeout: got %0d beats after %0d cycles, required %0d", name, got.size(), cyc, expq.size());
        end
        compare_groups(name);
        for (int p = 0; p < 4; p++) srcq[p].delete();
        M_TREADY = 1'b1;
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [15:0] w, input logic last);
        S_TVALID[p] = v; S_TDATA[p*80 +: 80] = {5{w}}; S_TLAST[p] = last; S_TUSER[p] = 1'b0;
    endtask

    task automatic wait_hs(input string name, input int p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ACLK);
            if (S_TVALID[p] && S_TREADY[p]) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s handshake_port%0d: got none within 50 cycles, required one", name, p);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_reset();
        ARESET_N = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check4("reset_s_tready", S_TREADY, 4'b0000);
        check4("reset_d_tvalid", {3'b000, D_TVALID}, 4'b0000);
        check4("reset_m_tid", {2'b00, M_TID}, 4'b0000);
        check4("reset_wd_err", WD_ERR, 4'b0000);
        @(posedge ACLK); #1 ARESET_N = 1'b1;
        @(negedge ACLK);
        check4("post_reset_s_tready", S_TREADY, 4'b0000);
    endtask

    task automatic test_round_robin();
        EN_MASK = 4'b1111;
        for (int r = 0; r < 2; r++) for (int p = 0; p < 4; p++) add_frame(p, 1, 1'b0);
        run_traffic("round_robin", 1'b0);
    endtask

    task automatic test_frame_lock();
        EN_MASK = 4'b1111;
        add_frame(1, 1, 1'b0);
        add_frame(1, 1, 1'b0);
        add_frame(2, 3, 1'b0);
        run_traffic("frame_lock", 1'b1);
    endtask

    task automatic test_en_mask();
        EN_MASK = 4'b0010;
        add_frame(0, 1, 1'b1);
        add_frame(1, 1, 1'b1);
        run_traffic("en_mask", 1'b0);
        EN_MASK = 4'b1111;
    endtask

    task automatic test_prio();
        for (int r = 0; r < 3; r++) begin
            add_frame(0, 1, 1'b0);
            add_frame(2, 1, 1'b0);
        end
        run_traffic("prio_0_vs_2", 1'b0);
    endtask

    task automatic test_watchdog();
        logic [15:0] w3, w0;
        obeat_t o;
        int cyc;
        w3 = 16'($urandom); w0 = 16'($urandom);
        expq.delete(); got.delete();
        M_TREADY = 1'b1; EN_MASK = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            o.tid = 2'd3; o.data = w3 + 16'(k); o.last = (k == 3); o.user = 1'b0; expq.push_back(o);
        end
        for (int k = 0; k < 4; k++) begin
            o.tid = 2'd0; o.data = w0 + 16'(k); o.last = (k == 3); o.user = 1'b0; expq.push_back(o);
        end
        set_port(3, 1'b1, w3, 1'b0);
        wait_hs("watchdog", 3);
        set_port(3, 1'b0, w3, 1'b0);
        set_port(0, 1'b1, w0, 1'b1);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check4("wd_err_after_3_idle", WD_ERR, 4'b0000);
        check4("wd_locked_port0_not_ready", {3'b000, S_TREADY[0]}, 4'b0000);
        @(posedge ACLK);
        @(negedge ACLK);
        check4("wd_err_after_4_idle", WD_ERR, 4'b1000);
        check4("wd_idle_d_tvalid", {3'b000, D_TVALID}, 4'b0000);
        wait_hs("watchdog", 0);
        set_port(0, 1'b0, w0, 1'b0);
        cyc = 0;
        while (got.size() < expq.size() && cyc < 200) begin
            @(posedge ACLK); cyc++;
        end
        @(negedge ACLK);
        compare_groups("watchdog_order");
        check4("wd_err_held", WD_ERR, 4'b1000);
        @(posedge ACLK); #1 WD_CLR = 4'b1000;
        @(posedge ACLK); #1 WD_CLR = 4'b0000;
        @(negedge ACLK);
        check4("wd_err_cleared", WD_ERR, 4'b0000);
        model_last = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            EN_MASK = 4'($urandom);
            for (int p = 0; p < 4; p++) begin
                int nf;
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 3), 1'($urandom));
            end
            run_traffic("random", 1'b1);
        end
        EN_MASK = 4'b1111;
    endtask

    task automatic test_reset_mid();
        M_TREADY = 1'b0;
        set_port(2, 1'b1, 16'($urandom), 1'b0);
        wait_hs("reset_mid", 2);
        set_port(2, 1'b1, 16'($urandom), 1'b1);
        ARESET_N = 1'b0;
        #2;
        check4("rst_mid_s_tready", S_TREADY, 4'b0000);
        check4("rst_mid_d_tvalid", {3'b000, D_TVALID}, 4'b0000);
        check4("rst_mid_m_tid", {2'b00, M_TID}, 4'b0000);
        check4("rst_mid_m_tvalid", {3'b000, M_TVALID}, 4'b0000);
        check4("rst_mid_wd_err", WD_ERR, 4'b0000);
        S_TVALID = 4'b0000;
        repeat (2) @(posedge ACLK);
        #1 ARESET_N = 1'b1;
        M_TREADY = 1'b1;
        model_last = 3;
        for (int p = 0; p < 4; p++) add_frame(p, 1, 1'b0);
        run_traffic("post_reset_grant", 1'b0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_frame_lock();
        test_en_mask();
        test_prio();
        test_watchdog();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
